// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel push-button debouncer with level, press and release outputs.
// Optional auto-repeat of press pulses while held: define MULTI_DEBOUNCER_REPEAT_EN.
module multi_debouncer #(
    parameter int CHANNELS      = 5,
    parameter int TICK_DIV      = 100000,
    parameter int STABLE_TICKS  = 10,
    parameter bit ACTIVE_LOW    = 1'b0,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] buttons_raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic                tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STABLE_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);

    // Raw idle value per channel; also used to fold polarity after the synchroniser.
    localparam logic [CHANNELS-1:0] RAW_IDLE = {CHANNELS{ACTIVE_LOW}};

    logic [TW-1:0]       tick_cnt;
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] s;
    logic [SW-1:0]       stab_cnt [CHANNELS];
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] rpt_fire;

    // Free-running sample divider; tick is a registered one-clock strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick <= (tick_cnt == TICK_LAST);
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // Two-flop synchroniser, reset to the idle pin value so reset never looks like a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= buttons_raw;
            sync2 <= sync1;
        end
    end

    assign s = sync2 ^ RAW_IDLE;

    // A channel accepts its new level on the tick that completes the disagreeing run.
    always_comb begin
        accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i] = tick && (s[i] != level[i]) && (stab_cnt[i] == STAB_LAST);
        end
    end

    // Per-channel run counter of consecutive disagreeing ticks; any agreement restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                stab_cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (s[i] == level[i] || accept[i]) begin
                    stab_cnt[i] <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef MULTI_DEBOUNCER_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]       rpt_cnt [CHANNELS];
    logic [CHANNELS-1:0] rpt_armed;

    // Repeat fires while held; a releasing tick never also repeats.
    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rpt_fire[i] = tick && level[i] && !accept[i] &&
                          (rpt_cnt[i] == (rpt_armed[i] ? PERIOD_LAST : DELAY_LAST));
        end
    end

    // Ticks since press (first interval) or since last repeat; cleared while released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                rpt_cnt[i] <= '0;
            end
            rpt_armed <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!level[i] || accept[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_armed[i] <= 1'b0;
                end else if (tick) begin
                    if (rpt_fire[i]) begin
                        rpt_cnt[i]   <= '0;
                        rpt_armed[i] <= 1'b1;
                    end else begin
                        rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end
`else
    // No auto-repeat: a press produces exactly one pulse.
    always_comb begin
        rpt_fire = '0;
    end
`endif

    // Level and edge pulses update together so pressed/released align with the level change.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level    <= '0;
            pressed  <= '0;
            released <= '0;
        end else begin
            level    <= level ^ accept;
            pressed  <= (accept & s) | rpt_fire;
            released <= accept & ~s;
        end
    end

endmodule
